// File: rtl/verify_ctrl_pkg.sv
// Shared types and constants for the verify session controller.
package verify_ctrl_pkg;

    // Session sequencer states
    typedef enum logic [2:0] {
        IDLE,
        FEED,
        WAIT_VERDICT,
        SEND,
        TX_WAIT
    } state_e;

    // Encoding reported on last_verdict
    typedef enum logic [1:0] {
        VERDICT_NONE = 2'd0,
        VERDICT_OK   = 2'd1,
        VERDICT_ERR  = 2'd2,
        VERDICT_TMO  = 2'd3
    } verdict_e;

    // Session framing byte
    localparam logic [7:0] DELIM = 8'h00;

endpackage

// File: rtl/byte_fifo.sv
// Synchronous byte FIFO with first-word fall-through read data.
// A push into a full FIFO is accepted when a pop frees a slot in the same cycle.
module byte_fifo #(
    parameter int DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push_i,
    input  logic [7:0] wdata_i,
    input  logic       pop_i,
    output logic [7:0] rdata_o,
    output logic       full_o,
    output logic       empty_o
);
    import verify_ctrl_pkg::*;

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    logic          do_push;
    logic          do_pop;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign rdata_o = mem_q[rd_ptr_q];

    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    // Storage array; contents need no reset, validity is tracked by count_q
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/verify_session_ctrl.sv
// Frames RX bytes into 0x00-delimited sessions, feeds them to the sequence
// checker, and reports each verdict as a single byte to the UART transmitter.
module verify_session_ctrl #(
    parameter int         FIFO_DEPTH  = 16,
    parameter int         TIMEOUT_CYC = 65535,
    parameter logic [7:0] OK_CHAR     = 8'h59,
    parameter logic [7:0] ERR_CHAR    = 8'h4E,
    parameter logic [7:0] TMO_CHAR    = 8'h54
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [7:0]  chk_char,
    output logic        chk_valid,
    output logic        chk_rst,
    input  logic        chk_seq_valid,
    input  logic        chk_strobe,
    output logic [7:0]  tx_data,
    output logic        tx_start,
    input  logic        tx_busy,
    output logic        busy,
    output logic        overflow,
    output logic [15:0] session_cnt,
    output logic [1:0]  last_verdict
);
    import verify_ctrl_pkg::*;

    localparam int               CNT_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYC - 1);

    state_e           state_q;
    logic [7:0]       chk_char_q;
    logic             chk_valid_q;
    logic             chk_rst_q;
    logic [7:0]       tx_data_q;
    logic             tx_start_q;
    logic             overflow_q;
    logic [15:0]      session_cnt_q;
    verdict_e         last_verdict_q;
    logic [CNT_W-1:0] tmo_cnt_q;
    logic             skip_q;

    logic             fifo_pop;
    logic [7:0]       fifo_rdata;
    logic             fifo_full;
    logic             fifo_empty;

    // Bytes are only consumed while hunting for or streaming a session
    assign fifo_pop = ((state_q == IDLE) || (state_q == FEED)) && !fifo_empty;

    byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (rx_valid),
        .wdata_i (rx_data),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign chk_char     = chk_char_q;
    assign chk_valid    = chk_valid_q;
    assign chk_rst      = chk_rst_q;
    assign tx_data      = tx_data_q;
    assign tx_start     = tx_start_q;
    assign busy         = (state_q != IDLE);
    assign overflow     = overflow_q;
    assign session_cnt  = session_cnt_q;
    assign last_verdict = last_verdict_q;

    // Session sequencer with registered strobes and status
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            chk_char_q     <= '0;
            chk_valid_q    <= 1'b0;
            chk_rst_q      <= 1'b0;
            tx_data_q      <= '0;
            tx_start_q     <= 1'b0;
            overflow_q     <= 1'b0;
            session_cnt_q  <= '0;
            last_verdict_q <= VERDICT_NONE;
            tmo_cnt_q      <= '0;
            skip_q         <= 1'b0;
        end else begin
            chk_valid_q <= 1'b0;
            chk_rst_q   <= 1'b0;
            tx_start_q  <= 1'b0;

            // A full FIFO still accepts a byte when a pop frees a slot this cycle
            if (rx_valid && fifo_full && !fifo_pop) begin
                overflow_q <= 1'b1;
            end

            case (state_q)
                IDLE: begin
                    if (fifo_pop && (fifo_rdata == DELIM)) begin
                        chk_char_q  <= fifo_rdata;
                        chk_valid_q <= 1'b1;
                        state_q     <= FEED;
                    end
                end
                FEED: begin
                    if (fifo_pop) begin
                        chk_char_q  <= fifo_rdata;
                        chk_valid_q <= 1'b1;
                        if (fifo_rdata == DELIM) begin
                            tmo_cnt_q <= '0;
                            state_q   <= WAIT_VERDICT;
                        end
                    end
                end
                WAIT_VERDICT: begin
                    // Strobe takes priority over a coincident timeout
                    if (chk_strobe) begin
                        tx_data_q      <= chk_seq_valid ? OK_CHAR : ERR_CHAR;
                        last_verdict_q <= chk_seq_valid ? VERDICT_OK : VERDICT_ERR;
                        state_q        <= SEND;
                    end else if (tmo_cnt_q == TMO_LAST) begin
                        tx_data_q      <= TMO_CHAR;
                        last_verdict_q <= VERDICT_TMO;
                        chk_rst_q      <= 1'b1;
                        state_q        <= SEND;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + 1'b1;
                    end
                end
                SEND: begin
                    if (!tx_busy) begin
                        tx_start_q <= 1'b1;
                        skip_q     <= 1'b1;
                        state_q    <= TX_WAIT;
                    end
                end
                TX_WAIT: begin
                    // tx_busy only rises the cycle after tx_start, so ignore the first cycle
                    if (skip_q) begin
                        skip_q <= 1'b0;
                    end else if (!tx_busy) begin
                        session_cnt_q <= session_cnt_q + 1'b1;
                        state_q       <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_verify_session_ctrl.sv
// Directed bench for verify_session_ctrl: sessions, junk, verdicts, timeout,
// overflow and asynchronous reset.
module tb_verify_session_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rx_data = '0;
    logic        rx_valid = 1'b0;
    logic [7:0]  chk_char;
    logic        chk_valid;
    logic        chk_rst;
    logic        chk_seq_valid = 1'b0;
    logic        chk_strobe = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        tx_busy = 1'b0;
    logic        busy;
    logic        overflow;
    logic [15:0] session_cnt;
    logic [1:0]  last_verdict;

    int total = 0;
    int bad   = 0;

    logic [7:0]  q_chk[$];
    logic [7:0]  q_tx[$];
    logic [7:0]  stim[$];
    int unsigned cyc = 0;
    int unsigned last_chk_cyc = 0;
    int unsigned rst_cyc = 0;
    int unsigned rst_cnt = 0;

    verify_session_ctrl #(
        .FIFO_DEPTH  (16),
        .TIMEOUT_CYC (100)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .chk_char      (chk_char),
        .chk_valid     (chk_valid),
        .chk_rst       (chk_rst),
        .chk_seq_valid (chk_seq_valid),
        .chk_strobe    (chk_strobe),
        .tx_data       (tx_data),
        .tx_start      (tx_start),
        .tx_busy       (tx_busy),
        .busy          (busy),
        .overflow      (overflow),
        .session_cnt   (session_cnt),
        .last_verdict  (last_verdict)
    );

    always #5 clk = ~clk;

    // Output monitor, sampled 1 ns after each rising edge
    initial begin
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (chk_valid) begin
                q_chk.push_back(chk_char);
                last_chk_cyc = cyc;
            end
            if (chk_rst) begin
                rst_cnt++;
                rst_cyc = cyc;
            end
            if (tx_start) q_tx.push_back(tx_data);
        end
    end

    // UART TX model: busy for 4 cycles starting the cycle after tx_start
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (tx_start && !rst) begin
                tx_busy = 1'b1;
                repeat (4) @(posedge clk);
                #1;
                tx_busy = 1'b0;
            end
        end
    end

    task automatic push_stim();
        foreach (stim[i]) begin
            @(negedge clk);
            rx_data  = stim[i];
            rx_valid = 1'b1;
        end
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic pulse_strobe(input logic valid);
        @(negedge clk);
        chk_seq_valid = valid;
        chk_strobe    = 1'b1;
        @(negedge clk);
        chk_strobe    = 1'b0;
    endtask

    task automatic wait_chk(input int n, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (q_chk.size() >= n) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic wait_tx(input int n, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (q_tx.size() >= n) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if ({chk_valid, chk_rst, tx_start, busy, overflow} !== 5'b0) begin
            bad++;
            $display("FAIL reset_flags: got %b want 00000", {chk_valid, chk_rst, tx_start, busy, overflow});
        end
        total++;
        if ({chk_char, tx_data} !== 16'h0000) begin
            bad++;
            $display("FAIL reset_bytes: got %h want 0000", {chk_char, tx_data});
        end
        total++;
        if (session_cnt !== 16'd0 || last_verdict !== 2'd0) begin
            bad++;
            $display("FAIL reset_status: got cnt=%0d lv=%0d want 0 0", session_cnt, last_verdict);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_normal();
        bit ok;
        q_chk.delete();
        q_tx.delete();
        stim = '{8'h00, 8'h61, 8'h62, 8'h00};
        push_stim();
        wait_chk(4, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL normal_feed_wait: got %0d bytes want 4", q_chk.size()); end
        repeat (20) @(negedge clk);
        pulse_strobe(1'b1);
        wait_idle(ok);
        total++;
        if (!ok) begin bad++; $display("FAIL normal_idle_wait: got busy=%b want 0", busy); end
        total++;
        if (q_chk.size() != 4 || q_chk[0] !== 8'h00 || q_chk[1] !== 8'h61 || q_chk[2] !== 8'h62 || q_chk[3] !== 8'h00) begin
            bad++;
            $display("FAIL normal_chk_bytes: got %p want 00 61 62 00", q_chk);
        end
        total++;
        if (q_tx.size() != 1 || q_tx[0] !== 8'h59) begin
            bad++;
            $display("FAIL normal_tx: got %p want 59", q_tx);
        end
        total++;
        if (session_cnt !== 16'd1 || last_verdict !== 2'd1) begin
            bad++;
            $display("FAIL normal_status: got cnt=%0d lv=%0d want 1 1", session_cnt, last_verdict);
        end
        total++;
        if (rst_cnt != 0) begin bad++; $display("FAIL normal_no_chk_rst: got %0d want 0", rst_cnt); end
    endtask

    task automatic test_leading_junk();
        bit ok;
        q_chk.delete();
        q_tx.delete();
        stim = '{8'h78, 8'h79, 8'h00, 8'h51, 8'h00};
        push_stim();
        wait_chk(3, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL junk_feed_wait: got %0d bytes want 3", q_chk.size()); end
        pulse_strobe(1'b1);
        wait_idle(ok);
        total++;
        if (q_chk.size() != 3 || q_chk[0] !== 8'h00 || q_chk[1] !== 8'h51 || q_chk[2] !== 8'h00) begin
            bad++;
            $display("FAIL junk_chk_bytes: got %p want 00 51 00", q_chk);
        end
        total++;
        if (session_cnt !== 16'd2 || q_tx.size() != 1 || q_tx[0] !== 8'h59) begin
            bad++;
            $display("FAIL junk_verdict: got cnt=%0d tx=%p want 2 59", session_cnt, q_tx);
        end
    endtask

    task automatic test_invalid();
        bit ok;
        q_chk.delete();
        q_tx.delete();
        stim = '{8'h00, 8'h41, 8'h00};
        push_stim();
        wait_chk(3, ok);
        pulse_strobe(1'b0);
        wait_idle(ok);
        total++;
        if (q_tx.size() != 1 || q_tx[0] !== 8'h4E) begin
            bad++;
            $display("FAIL invalid_tx: got %p want 4e", q_tx);
        end
        total++;
        if (last_verdict !== 2'd2 || session_cnt !== 16'd3) begin
            bad++;
            $display("FAIL invalid_status: got lv=%0d cnt=%0d want 2 3", last_verdict, session_cnt);
        end
    endtask

    task automatic test_timeout();
        bit ok;
        q_chk.delete();
        q_tx.delete();
        stim = '{8'h00, 8'h43, 8'h00};
        push_stim();
        wait_chk(3, ok);
        wait_tx(1, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL timeout_tx_wait: got %0d tx want 1", q_tx.size()); end
        total++;
        if (rst_cnt != 1 || (rst_cyc - last_chk_cyc) != 100) begin
            bad++;
            $display("FAIL timeout_chk_rst: got pulses=%0d delay=%0d want 1 100", rst_cnt, rst_cyc - last_chk_cyc);
        end
        total++;
        if (q_tx[0] !== 8'h54 || last_verdict !== 2'd3) begin
            bad++;
            $display("FAIL timeout_verdict: got tx=%h lv=%0d want 54 3", q_tx[0], last_verdict);
        end
        wait_idle(ok);
        total++;
        if (!ok || session_cnt !== 16'd4) begin
            bad++;
            $display("FAIL timeout_idle: got busy=%b cnt=%0d want 0 4", busy, session_cnt);
        end
    endtask

    task automatic test_stray_strobe();
        q_tx.delete();
        pulse_strobe(1'b0);
        repeat (10) @(negedge clk);
        total++;
        if (q_tx.size() != 0 || session_cnt !== 16'd4 || last_verdict !== 2'd3 || busy !== 1'b0) begin
            bad++;
            $display("FAIL stray_strobe: got tx=%0d cnt=%0d lv=%0d busy=%b want 0 4 3 0",
                     q_tx.size(), session_cnt, last_verdict, busy);
        end
    endtask

    task automatic test_overflow();
        bit ok;
        bit seen_z;
        q_chk.delete();
        q_tx.delete();
        total++;
        if (overflow !== 1'b0) begin bad++; $display("FAIL overflow_pre: got %b want 0", overflow); end
        stim = '{8'h00, 8'h41, 8'h00};
        push_stim();
        wait_chk(3, ok);
        // 16 bytes fill the FIFO while waiting for a verdict; the 17th is dropped
        stim.delete();
        stim.push_back(8'h00);
        for (int i = 0; i < 14; i++) stim.push_back(8'h61 + 8'(i));
        stim.push_back(8'h00);
        stim.push_back(8'h5A);
        push_stim();
        total++;
        if (overflow !== 1'b1) begin bad++; $display("FAIL overflow_set: got %b want 1", overflow); end
        pulse_strobe(1'b1);
        wait_chk(19, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL overflow_drain_wait: got %0d bytes want 19", q_chk.size()); end
        pulse_strobe(1'b1);
        wait_idle(ok);
        repeat (5) @(negedge clk);
        seen_z = 1'b0;
        foreach (q_chk[i]) if (q_chk[i] === 8'h5A) seen_z = 1'b1;
        total++;
        if (q_chk.size() != 19 || seen_z || q_chk[3] !== 8'h00 || q_chk[4] !== 8'h61 || q_chk[17] !== 8'h6E || q_chk[18] !== 8'h00) begin
            bad++;
            $display("FAIL overflow_bytes: got n=%0d z=%b want 19 0", q_chk.size(), seen_z);
        end
        total++;
        if (session_cnt !== 16'd6 || q_tx.size() != 2 || overflow !== 1'b1) begin
            bad++;
            $display("FAIL overflow_status: got cnt=%0d tx=%0d ovf=%b want 6 2 1", session_cnt, q_tx.size(), overflow);
        end
    endtask

    task automatic test_async_reset();
        bit ok;
        q_chk.delete();
        stim = '{8'h00, 8'h41, 8'h42};
        push_stim();
        wait_chk(2, ok);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        total++;
        if ({chk_valid, chk_rst, tx_start, busy, overflow} !== 5'b0 || chk_char !== 8'h00) begin
            bad++;
            $display("FAIL async_rst_outputs: got %b %h want 00000 00",
                     {chk_valid, chk_rst, tx_start, busy, overflow}, chk_char);
        end
        total++;
        if (session_cnt !== 16'd0 || last_verdict !== 2'd0 || tx_data !== 8'h00) begin
            bad++;
            $display("FAIL async_rst_status: got cnt=%0d lv=%0d tx=%h want 0 0 00", session_cnt, last_verdict, tx_data);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        q_chk.delete();
        repeat (10) @(negedge clk);
        total++;
        if (q_chk.size() != 0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL async_rst_fifo_empty: got bytes=%0d busy=%b want 0 0", q_chk.size(), busy);
        end
    endtask

    initial begin
        test_reset();
        test_normal();
        test_leading_junk();
        test_invalid();
        test_timeout();
        test_stray_strobe();
        test_overflow();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard stop in case a task never returns
    initial begin
        #200000;
        $display("FAIL global_timeout: got no completion want completion");
        $fatal(1);
    end

endmodule

// File: doc/verify_session_ctrl.md
Name: verify_session_ctrl

Overview:
Sequences the ASCII sequence checker (verify) between a UART receiver and a UART transmitter. Buffers incoming bytes in a FIFO and frames each session between 0x00 delimiters. Feeds one byte per cycle to the checker, waits for its verdict strobe, and transmits a one-byte verdict ('Y'/'N'/'T'). Recovers a hung checker with a timeout and a checker reset pulse.

Parameters:
FIFO_DEPTH, 16, RX byte buffer depth (power of two, >=2)
TIMEOUT_CYC, 65535, max cycles in WAIT_VERDICT before declaring timeout (>=1)
OK_CHAR, 8'h59, verdict byte for a valid sequence ('Y')
ERR_CHAR, 8'h4E, verdict byte for an invalid sequence ('N')
TMO_CHAR, 8'h54, verdict byte for a timeout ('T')

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high; all state cleared on assertion
rx_data  in  8  received byte
rx_valid  in  1  one-cycle pulse, rx_data is valid
chk_char  out  8  byte presented to the checker
chk_valid  out  1  one-cycle pulse, chk_char is valid
chk_rst  out  1  one-cycle synchronous reset pulse to the checker
chk_seq_valid  in  1  checker verdict: 1 = sequence valid
chk_strobe  in  1  checker verdict strobe, one cycle
tx_data  out  8  verdict byte to the UART TX
tx_start  out  1  one-cycle request to the UART TX
tx_busy  in  1  UART TX busy; rises the cycle after tx_start
busy  out  1  high whenever the FSM is not in IDLE
overflow  out  1  sticky; a byte was dropped because the FIFO was full
session_cnt  out  16  count of verdicts sent; wraps at 0xFFFF -> 0
last_verdict  out  2  0 = none, 1 = ok, 2 = err, 3 = timeout

Behaviour:
- Reset (async): FSM=IDLE; FIFO empty; all outputs 0; timeout counter 0.
- FIFO write: push rx_data when rx_valid && !full, in any state. If full, drop the byte and set overflow (cleared only by rst).
- Simultaneous push and pop when full: the pop frees a slot, so the push is accepted.
- chk_char, chk_valid, tx_data, tx_start and chk_rst are registered. Latency from pop to chk_valid is 1 cycle.
- IDLE: pop one byte per cycle while non-empty.
  - Byte != 0x00: discard; chk_valid stays 0.
  - Byte == 0x00: drive it to the checker and go to FEED.
- FEED: pop one byte per cycle while non-empty; each pop produces a chk_valid pulse with that byte.
  - An empty FIFO inserts gaps; it is not an error.
  - Popped byte == 0x00: feed it, clear the timeout counter, go to WAIT_VERDICT.
- WAIT_VERDICT: no pops (RX keeps filling the FIFO); the counter increments every cycle.
  - chk_strobe=1: latch tx_data = chk_seq_valid ? OK_CHAR : ERR_CHAR, set last_verdict to 1 or 2, go to SEND.
  - Counter == TIMEOUT_CYC-1 with no strobe: tx_data = TMO_CHAR, last_verdict = 3, chk_rst pulse for 1 cycle, go to SEND.
  - If the strobe and the timeout occur in the same cycle, the strobe wins.
- SEND: wait for tx_busy==0, then pulse tx_start for 1 cycle and go to TX_WAIT.
- TX_WAIT: skip the first cycle, then wait for tx_busy==0. On exit, session_cnt+1 (wrapping) and go to IDLE.
- A chk_strobe outside WAIT_VERDICT is ignored.

Decomposition:
- Package verify_ctrl_pkg holds:
  - state enum: IDLE, FEED, WAIT_VERDICT, SEND, TX_WAIT
  - last_verdict codes
  - DELIM = 8'h00
- One sub-module: byte_fifo (synchronous FIFO; push/pop/full/empty; parameter DEPTH; async active-high rst).

Test Plan:
- Normal session: rx 00,'a','b',00; checker model strobes with seq_valid=1 after 20 cycles -> chk_valid pulses 4 times with 00,61,62,00 in order; then tx_start once with tx_data=0x59; session_cnt=1; last_verdict=1.
- Leading junk: rx 'x','y',00,'Q',00 -> 0x78 and 0x79 never appear on chk_valid; the first fed byte is 00; 3 chk_valid pulses total.
- Invalid sequence: strobe with seq_valid=0 -> tx_data=0x4E; last_verdict=2.
- Timeout with TIMEOUT_CYC=100: no strobe -> at cycle 100 in WAIT_VERDICT, chk_rst pulses 1 cycle; tx_data=0x54; FSM returns to IDLE after tx_busy drops.
- Overflow with FIFO_DEPTH=16 while in WAIT_VERDICT: push 17 bytes -> 17th dropped; overflow=1; after the verdict, exactly 16 bytes are processed.
- Async rst asserted mid-FEED, between clock edges -> outputs 0 and busy=0 immediately; FIFO empty; session_cnt=0.
